// File: rtl/ex_mem_skid_if.sv
// EX->MEM beat bus: valid/ready handshake, beat payload and flush.
// slave = pipeline register side, master = EX/MEM driver side.
interface ex_mem_skid_if;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] alu_result_i;
    logic        alu_zero_i;
    logic [31:0] rt_data_i;
    logic [4:0]  wb_reg_i;
    logic [3:0]  ctrl_i;
    logic [31:0] branch_target_i;
    logic        flush_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] alu_result_o;
    logic [31:0] rt_data_o;
    logic [31:0] branch_target_o;
    logic [4:0]  wb_reg_o;
    logic [3:0]  ctrl_o;
    logic        branch_taken_o;
    logic [15:0] stall_cnt_o;

    modport slave (
        input  in_valid_i, alu_result_i, alu_zero_i, rt_data_i,
        input  wb_reg_i, ctrl_i, branch_target_i, flush_i,
        input  out_ready_i,
        output in_ready_o, out_valid_o, alu_result_o, rt_data_o,
        output branch_target_o, wb_reg_o, ctrl_o, branch_taken_o,
        output stall_cnt_o
    );

    modport master (
        output in_valid_i, alu_result_i, alu_zero_i, rt_data_i,
        output wb_reg_i, ctrl_i, branch_target_i, flush_i,
        output out_ready_i,
        input  in_ready_o, out_valid_o, alu_result_o, rt_data_o,
        input  branch_target_o, wb_reg_o, ctrl_o, branch_taken_o,
        input  stall_cnt_o
    );
endinterface

// File: rtl/ex_mem_skid.sv
// EX/MEM pipeline register as a 2-entry skid FIFO (main + skid).
// Ports: clk_i, rst_i (sync, active-high), bus (ex_mem_skid_if.slave).
module ex_mem_skid (
    input logic          clk_i,
    input logic          rst_i,
    ex_mem_skid_if.slave bus
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] rt;
        logic [31:0] tgt;
        logic [4:0]  wb;
        logic [3:0]  ctrl;
        logic        taken;
    } beat_t;

    state_t      r_state;
    state_t      w_next;
    beat_t       r_main;
    beat_t       r_skid;
    beat_t       w_in;
    logic [15:0] r_stall;
    logic        w_accept;
    logic        w_pop;
    logic        w_ld_main_in;
    logic        w_ld_main_skid;
    logic        w_ld_skid;

    // Ready drops during reset so nothing is accepted while it is held.
    assign bus.in_ready_o  = (r_state != TWO) && !rst_i;
    assign bus.out_valid_o = (r_state != EMPTY);

    assign w_accept = bus.in_valid_i && bus.in_ready_o;
    assign w_pop    = bus.out_valid_o && bus.out_ready_i;

    always_comb begin
        w_in       = '0;
        w_in.alu   = bus.alu_result_i;
        w_in.rt    = bus.rt_data_i;
        w_in.tgt   = bus.branch_target_i;
        w_in.wb    = bus.wb_reg_i;
        w_in.ctrl  = bus.ctrl_i;
        w_in.taken = bus.ctrl_i[0] && bus.alu_zero_i;
    end

    always_comb begin
        w_next         = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        if (bus.flush_i) begin
            // Flush wins: any same-cycle accept or pop is dropped.
            w_next = EMPTY;
        end else begin
            unique case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_next       = ONE;
                        w_ld_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (w_accept && w_pop) begin
                        w_ld_main_in = 1'b1;
                    end else if (w_accept) begin
                        w_next    = TWO;
                        w_ld_skid = 1'b1;
                    end else if (w_pop) begin
                        w_next = EMPTY;
                    end
                end
                TWO: begin
                    if (w_pop) begin
                        w_next         = ONE;
                        w_ld_main_skid = 1'b1;
                    end
                end
                default: w_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_ld_main_in) begin
                r_main <= w_in;
            end else if (w_ld_main_skid) begin
                r_main <= r_skid;
            end
            if (w_ld_skid) begin
                r_skid <= w_in;
            end
        end
    end

    // Stall counter ignores flush and saturates.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall <= '0;
        end else if (bus.out_valid_o && !bus.out_ready_i
                     && r_stall != 16'hFFFF) begin
            r_stall <= r_stall + 16'd1;
        end
    end

    assign bus.alu_result_o    = r_main.alu;
    assign bus.rt_data_o       = r_main.rt;
    assign bus.branch_target_o = r_main.tgt;
    assign bus.wb_reg_o        = r_main.wb;
    assign bus.ctrl_o          = r_main.ctrl;
    assign bus.branch_taken_o  = r_main.taken;
    assign bus.stall_cnt_o     = r_stall;

endmodule

// File: tb/tb_ex_mem_skid.sv
// Directed bench for ex_mem_skid.
// Inputs change #1 after posedge; outputs sampled there too.
module tb_ex_mem_skid;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    ex_mem_skid_if bus ();

    ex_mem_skid dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] alu,
                        input logic [3:0] ctrl,
                        input logic zero,
                        input logic [31:0] tgt);
        bus.in_valid_i      = 1'b1;
        bus.alu_result_i    = alu;
        bus.rt_data_i       = ~alu;
        bus.wb_reg_i        = alu[4:0];
        bus.ctrl_i          = ctrl;
        bus.alu_zero_i      = zero;
        bus.branch_target_i = tgt;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst   = 1'b1;
        bus.flush_i     = 1'b0;
        bus.out_ready_i = 1'b0;
        beat(32'h99, 4'hF, 1'b1, 32'h1234);
        step();
        step();
        check("rst_valid", 32'(bus.out_valid_o), 32'd0);
        check("rst_ready", 32'(bus.in_ready_o), 32'd0);
        check("rst_alu", bus.alu_result_o, 32'd0);
        check("rst_stall", 32'(bus.stall_cnt_o), 32'd0);
        check("rst_taken", 32'(bus.branch_taken_o), 32'd0);
        rst = 1'b0;
        bus.in_valid_i = 1'b0;
        #1;
        check("post_rst_ready", 32'(bus.in_ready_o), 32'd1);
        check("post_rst_valid", 32'(bus.out_valid_o), 32'd0);

        // single beat
        beat(32'h5, 4'h8, 1'b0, 32'h0);
        bus.wb_reg_i = 5'd3;
        step();
        bus.in_valid_i = 1'b0;
        check("one_valid", 32'(bus.out_valid_o), 32'd1);
        check("one_alu", bus.alu_result_o, 32'h5);
        check("one_wb", 32'(bus.wb_reg_o), 32'd3);
        check("one_ctrl", 32'(bus.ctrl_o), 32'h8);
        check("one_rt", bus.rt_data_o, ~32'h5);
        bus.out_ready_i = 1'b1;
        step();
        check("one_drain", 32'(bus.out_valid_o), 32'd0);
        check("one_hold", bus.alu_result_o, 32'h5);
        check("one_stall", 32'(bus.stall_cnt_o), 32'd0);

        // skid fill
        bus.out_ready_i = 1'b0;
        beat(32'h11, 4'h8, 1'b0, 32'h0);
        step();
        beat(32'h22, 4'h8, 1'b0, 32'h0);
        step();
        beat(32'h33, 4'h8, 1'b0, 32'h0);
        step();
        bus.in_valid_i = 1'b0;
        check("skid_ready", 32'(bus.in_ready_o), 32'd0);
        check("skid_stall", 32'(bus.stall_cnt_o), 32'd2);
        check("skid_a", bus.alu_result_o, 32'h11);
        bus.out_ready_i = 1'b1;
        step();
        check("skid_b_valid", 32'(bus.out_valid_o), 32'd1);
        check("skid_b", bus.alu_result_o, 32'h22);
        step();
        check("skid_empty", 32'(bus.out_valid_o), 32'd0);
        check("skid_stall2", 32'(bus.stall_cnt_o), 32'd2);

        // streaming
        for (int i = 1; i <= 8; i++) begin
            beat(32'(i), 4'h8, 1'b0, 32'h0);
            #1;
            check("strm_ready", 32'(bus.in_ready_o), 32'd1);
            step();
            check("strm_valid", 32'(bus.out_valid_o), 32'd1);
            check("strm_alu", bus.alu_result_o, 32'(i));
        end
        bus.in_valid_i = 1'b0;
        step();
        check("strm_end", 32'(bus.out_valid_o), 32'd0);

        // branch
        beat(32'h0, 4'h1, 1'b1, 32'h40);
        step();
        check("br_taken", 32'(bus.branch_taken_o), 32'd1);
        check("br_tgt", bus.branch_target_o, 32'h40);
        beat(32'h0, 4'h1, 1'b0, 32'h80);
        step();
        check("br_not", 32'(bus.branch_taken_o), 32'd0);
        check("br_tgt2", bus.branch_target_o, 32'h80);
        beat(32'h0, 4'h0, 1'b1, 32'hC0);
        step();
        check("br_noctrl", 32'(bus.branch_taken_o), 32'd0);
        bus.in_valid_i = 1'b0;
        step();

        // flush from TWO with pop and accept
        bus.out_ready_i = 1'b0;
        beat(32'hAA, 4'h8, 1'b0, 32'h0);
        step();
        beat(32'hBB, 4'h8, 1'b0, 32'h0);
        step();
        check("fl_two", 32'(bus.in_ready_o), 32'd0);
        beat(32'hCC, 4'h8, 1'b0, 32'h0);
        bus.flush_i     = 1'b1;
        bus.out_ready_i = 1'b1;
        step();
        bus.flush_i    = 1'b0;
        bus.in_valid_i = 1'b0;
        check("fl_valid", 32'(bus.out_valid_o), 32'd0);
        check("fl_ready", 32'(bus.in_ready_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("fl_quiet", 32'(bus.out_valid_o), 32'd0);
        end
        check("fl_stall", 32'(bus.stall_cnt_o), 32'd3);

        // reset mid-stream
        bus.out_ready_i = 1'b0;
        beat(32'h77, 4'h8, 1'b0, 32'h0);
        step();
        bus.in_valid_i = 1'b0;
        step();
        step();
        check("mr_stall5", 32'(bus.stall_cnt_o), 32'd5);
        check("mr_valid1", 32'(bus.out_valid_o), 32'd1);
        rst = 1'b1;
        step();
        check("mr_valid", 32'(bus.out_valid_o), 32'd0);
        check("mr_stall", 32'(bus.stall_cnt_o), 32'd0);
        check("mr_alu", bus.alu_result_o, 32'd0);
        rst = 1'b0;
        bus.out_ready_i = 1'b1;
        #1;
        check("mr_ready", 32'(bus.in_ready_o), 32'd1);
        for (int i = 0; i < 2; i++) begin
            step();
            check("mr_quiet", 32'(bus.out_valid_o), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
